// File: rtl/kd_tree_pkg.sv
// kd_tree_pkg: definitions shared by the kd-tree node, the root sequencer and
// their benches. It holds the node command encodings, the sequencer state
// encoding and a small counter-width helper.
package kd_tree_pkg;

  localparam int CMD_W = 5;

  // Node command bus encodings
  localparam logic [CMD_W-1:0] CMD_NOP              = 5'h00;
  localparam logic [CMD_W-1:0] CMD_CENTER_FILL      = 5'h01;
  localparam logic [CMD_W-1:0] CMD_CENTER_FILL_DONE = 5'h05;
  localparam logic [CMD_W-1:0] CMD_START_SORTING    = 5'h09;
  localparam logic [CMD_W-1:0] CMD_READY_TO_SORT    = 5'h0a;
  localparam logic [CMD_W-1:0] CMD_DNE              = 5'h10;
  localparam logic [CMD_W-1:0] CMD_RST_DONE         = 5'h1e;
  localparam logic [CMD_W-1:0] CMD_RST              = 5'h1f;

  // Sequencer states, kept as plain constants so older tools can read them
  typedef logic [2:0] seq_state_t;
  localparam seq_state_t ST_IDLE      = 3'd0;
  localparam seq_state_t ST_TREE_RST  = 3'd1;
  localparam seq_state_t ST_FILL      = 3'd2;
  localparam seq_state_t ST_FILL_WAIT = 3'd3;
  localparam seq_state_t ST_SORT      = 3'd4;
  localparam seq_state_t ST_DRAIN     = 3'd5;
  localparam seq_state_t ST_DONE      = 3'd6;
  localparam seq_state_t ST_ERROR     = 3'd7;

  // Bits needed to hold the values 0..max_value, never less than one bit
  function automatic int cnt_width(input int max_value);
    int w;
    w = $clog2(max_value + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/kd_tree_sequencer_watchdog.sv
// kd_seq_watchdog: counts enabled cycles and flags expiry once TIMEOUT
// enabled cycles have elapsed since the last clear. The counter holds at the
// expiry value until cleared, so expired stays asserted while enable is high.
// Only instantiated by kd_tree_sequencer when KD_SEQ_TIMEOUT_EN is defined.
module kd_seq_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  import kd_tree_pkg::*;

  localparam int WD_W = cnt_width(TIMEOUT);
  localparam logic [WD_W-1:0] LIMIT = WD_W'(TIMEOUT - 1);

  logic [WD_W-1:0] count_reg;

  assign expired = enable && (count_reg == LIMIT);

  // Count enabled cycles since the last clear, stopping at the limit
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_reg <= '0;
    end else if (enable && !expired) begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/kd_tree_sequencer.sv
// kd_tree_sequencer: drives the kd-tree root node through one complete run:
// tree reset, streaming NUM_CENTERS centers, start_sorting and a fixed drain
// window, then a done pulse. Reports busy/done/error and a saturating cycle
// count. Defining KD_SEQ_TIMEOUT_EN adds a watchdog on the wait states that
// ends a stuck run in ERROR; without it waits are unbounded and error is 0.
module kd_tree_sequencer #(
  parameter int DATA_W       = 24,
  parameter int CMD_W        = kd_tree_pkg::CMD_W,
  parameter int NUM_CENTERS  = 10,
  parameter int STALL_CYCLES = 10,
  parameter int TIMEOUT      = 1024,
  parameter int CNT_W        = 27
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              center_valid,
  input  logic [DATA_W-1:0] center_data,
  output logic              center_ready,
  output logic [CMD_W-1:0]  cmd_to_root,
  output logic [DATA_W-1:0] data_to_root,
  input  logic [CMD_W-1:0]  cmd_from_root,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  cycle_count
);
  import kd_tree_pkg::*;

  localparam int FILL_W  = cnt_width(NUM_CENTERS);
  localparam int DRAIN_W = cnt_width(STALL_CYCLES);

  localparam logic [FILL_W-1:0]  NUM_C    = FILL_W'(NUM_CENTERS);
  localparam logic [FILL_W-1:0]  NUM_LAST = FILL_W'(NUM_CENTERS - 1);
  localparam logic [DRAIN_W-1:0] STALL_C  = DRAIN_W'(STALL_CYCLES);

  // Commands resized to this instance's bus width
  localparam logic [CMD_W-1:0] C_NOP       = CMD_W'(CMD_NOP);
  localparam logic [CMD_W-1:0] C_FILL      = CMD_W'(CMD_CENTER_FILL);
  localparam logic [CMD_W-1:0] C_FILL_DONE = CMD_W'(CMD_CENTER_FILL_DONE);
  localparam logic [CMD_W-1:0] C_SORT      = CMD_W'(CMD_START_SORTING);
  localparam logic [CMD_W-1:0] C_RST_DONE  = CMD_W'(CMD_RST_DONE);
  localparam logic [CMD_W-1:0] C_RST       = CMD_W'(CMD_RST);

  seq_state_t          state_reg, state_next;
  logic [FILL_W-1:0]   fill_cnt_reg;
  logic [DRAIN_W-1:0]  drain_cnt_reg;
  logic                early_full_reg;
  logic [CMD_W-1:0]    cmd_reg;
  logic [DATA_W-1:0]   data_reg;
  logic                busy_reg, done_reg, error_reg;
  logic [CNT_W-1:0]    count_reg;

  logic start_accept;
  logic handshake;
  logic wd_expired;

  // Ready depends only on state and fill count, never on center_valid
  assign center_ready = (state_reg == ST_FILL) && (fill_cnt_reg < NUM_C);
  assign handshake    = center_valid && center_ready;
  assign start_accept = start && ((state_reg == ST_IDLE) || (state_reg == ST_ERROR));

  assign cmd_to_root  = cmd_reg;
  assign data_to_root = data_reg;
  assign busy         = busy_reg;
  assign done         = done_reg;
  assign error        = error_reg;
  assign cycle_count  = count_reg;

`ifdef KD_SEQ_TIMEOUT_EN
  logic wd_enable;
  logic wd_clear;

  // The watchdog restarts on every state change and on every accepted center
  assign wd_enable = (state_reg == ST_TREE_RST) || (state_reg == ST_FILL) ||
                     (state_reg == ST_FILL_WAIT);
  assign wd_clear  = (state_next != state_reg) || handshake;

  kd_seq_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );
`else
  assign wd_expired = 1'b0;
`endif

  // Next-state decode
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start_accept) state_next = ST_TREE_RST;
      end
      ST_TREE_RST: begin
        if (cmd_from_root == C_RST_DONE) state_next = ST_FILL;
        else if (wd_expired)             state_next = ST_ERROR;
      end
      ST_FILL: begin
        // An early center_fill_done still passes through FILL_WAIT so that
        // start_sorting is always preceded by a nop on the bus.
        if (handshake && (fill_cnt_reg == NUM_LAST))  state_next = ST_FILL_WAIT;
        else if (cmd_from_root == C_FILL_DONE)        state_next = ST_FILL_WAIT;
        else if (!handshake && wd_expired)            state_next = ST_ERROR;
      end
      ST_FILL_WAIT: begin
        if (early_full_reg || (cmd_from_root == C_FILL_DONE)) state_next = ST_SORT;
        else if (wd_expired)                                  state_next = ST_ERROR;
      end
      ST_SORT: begin
        state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (drain_cnt_reg == '0) state_next = ST_DONE;
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      ST_ERROR: begin
        if (start_accept) state_next = ST_TREE_RST;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State, counters and status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      fill_cnt_reg   <= '0;
      drain_cnt_reg  <= '0;
      early_full_reg <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      error_reg      <= 1'b0;
      count_reg      <= '0;
    end else begin
      state_reg <= state_next;
      busy_reg  <= (state_next != ST_IDLE) && (state_next != ST_DONE) &&
                   (state_next != ST_ERROR);
      done_reg  <= (state_next == ST_DONE);
      error_reg <= (state_next == ST_ERROR);

      if (start_accept) begin
        count_reg <= '0;
      end else if (busy_reg && (count_reg != '1)) begin
        count_reg <= count_reg + 1'b1;
      end

      if (start_accept) begin
        fill_cnt_reg <= '0;
      end else if (handshake) begin
        fill_cnt_reg <= fill_cnt_reg + 1'b1;
      end

      // Remembers that the tree reported full before all centers were sent
      if (start_accept) begin
        early_full_reg <= 1'b0;
      end else if ((state_reg == ST_FILL) && (cmd_from_root == C_FILL_DONE)) begin
        early_full_reg <= 1'b1;
      end

      if (state_reg == ST_SORT) begin
        drain_cnt_reg <= STALL_C;
      end else if ((state_reg == ST_DRAIN) && (drain_cnt_reg != '0)) begin
        drain_cnt_reg <= drain_cnt_reg - 1'b1;
      end
    end
  end

  // Registered command/data bus towards the root node
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_reg  <= C_NOP;
      data_reg <= '0;
    end else begin
      cmd_reg <= C_NOP;
      case (state_reg)
        ST_IDLE, ST_ERROR: begin
          if (start_accept) begin
            cmd_reg  <= C_RST;
            data_reg <= '0;
          end else if (state_reg == ST_IDLE) begin
            data_reg <= '0;
          end
        end
        ST_TREE_RST: begin
          if (state_next == ST_TREE_RST) cmd_reg <= C_RST;
        end
        ST_FILL: begin
          // A center accepted on the same edge as an early full is forwarded
          if (handshake) begin
            cmd_reg  <= C_FILL;
            data_reg <= center_data;
          end
        end
        ST_SORT: begin
          cmd_reg  <= C_SORT;
          data_reg <= '0;
        end
        default: begin
          cmd_reg <= C_NOP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kd_tree_sequencer.sv
// tb_kd_tree_sequencer: randomized bench for kd_tree_sequencer. A model tree
// answers rst and center_fill, a source streams centers, and a scoreboard
// queue holds the non-nop bus words each run must produce (rst words, the
// accepted centers in order, one start_sorting). A monitor pops and compares
// every non-nop word the DUT puts on the bus. The timeout scenario runs only
// when KD_SEQ_TIMEOUT_EN is defined.
module tb_kd_tree_sequencer;
  import kd_tree_pkg::*;

  localparam int NUM   = 10;
  localparam int STALL = 10;
  localparam int TO    = 16;
  localparam int DW    = 24;
  localparam int CW    = 27;

  typedef struct packed {
    logic [CMD_W-1:0] cmd;
    logic [DW-1:0]    data;
  } word_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              center_valid = 1'b0;
  logic [DW-1:0]     center_data = '0;
  logic              center_ready;
  logic [CMD_W-1:0]  cmd_to_root;
  logic [DW-1:0]     data_to_root;
  logic [CMD_W-1:0]  cmd_from_root = CMD_NOP;
  logic              busy, done, error;
  logic [CW-1:0]     cycle_count;

  kd_tree_sequencer #(
    .DATA_W (DW), .CMD_W (CMD_W), .NUM_CENTERS (NUM),
    .STALL_CYCLES (STALL), .TIMEOUT (TO), .CNT_W (CW)
  ) dut (
    .clk (clk), .reset (reset), .start (start),
    .center_valid (center_valid), .center_data (center_data),
    .center_ready (center_ready), .cmd_to_root (cmd_to_root),
    .data_to_root (data_to_root), .cmd_from_root (cmd_from_root),
    .busy (busy), .done (done), .error (error), .cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  word_t         exp_q[$];
  logic [DW-1:0] src_list[$];

  // Bench-wide knobs and monitor bookkeeping
  int  cyc = 0;
  int  busy_cycles = 0;
  int  ss_cyc = -1;
  int  done_cyc = -1;
  bit  done_seen = 0;
  logic prev_done = 1'b0;
  logic [CMD_W-1:0] prev_from_root = CMD_NOP;

  int  rst_delay = 3;
  int  fill_done_at = NUM;
  bit  tree_mute = 0;
  int  valid_mode = 0;
  bit  src_active = 0;
  int  src_idx = 0;
  bit  src_hs = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Model root node: answers rst after rst_delay cycles, and reports full
  // in the cycle the fill_done_at-th center_fill word reaches it.
  initial begin
    int rst_seen = 0;
    int fills = 0;
    forever begin
      @(posedge clk); #1;
      cmd_from_root = CMD_NOP;
      if (cmd_to_root == CMD_RST) begin
        fills = 0;
        rst_seen++;
        if (!tree_mute && rst_seen == rst_delay) cmd_from_root = CMD_RST_DONE;
      end else begin
        rst_seen = 0;
        if (cmd_to_root == CMD_CENTER_FILL) begin
          fills++;
          if (fills == fill_done_at) cmd_from_root = CMD_CENTER_FILL_DONE;
        end
      end
    end
  end

  // Center source: offers src_list in order, advancing after each handshake
  initial begin
    bit v;
    forever begin
      @(negedge clk);
      src_hs = center_valid && center_ready;
      @(posedge clk); #1;
      if (src_hs) src_idx++;
      case (valid_mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2) == 0;
        default: v = 1'($urandom_range(0, 1));
      endcase
      center_valid = src_active && v && (src_idx < src_list.size());
      center_data  = (src_idx < src_list.size()) ? src_list[src_idx] : '0;
    end
  end

  // Monitor: compares bus words with the scoreboard and watches handshakes
  initial begin
    word_t w;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        if (busy) busy_cycles++;
        if (cmd_to_root != CMD_NOP) begin
          if (exp_q.size() == 0) begin
            check("bus_word_unexpected", 32'(cmd_to_root), 32'(CMD_NOP));
          end else begin
            w = exp_q.pop_front();
            check("bus_cmd", 32'(cmd_to_root), 32'(w.cmd));
            check("bus_data", 32'(data_to_root), 32'(w.data));
          end
          if (cmd_to_root == CMD_START_SORTING) ss_cyc = cyc;
          if (cmd_to_root == CMD_RST) check("ready_during_rst", 32'(center_ready), 0);
        end
        if (prev_from_root == CMD_RST_DONE) check("ready_after_rst_done", 32'(center_ready), 1);
        if (done) begin
          done_seen = 1;
          done_cyc  = cyc;
          check("busy_at_done", 32'(busy), 0);
        end
        if (prev_done) check("done_one_cycle", 32'(done), 0);
      end
      prev_done      = done;
      prev_from_root = cmd_from_root;
    end
  end

  // Builds the expected bus words for one run and pulses start
  task automatic start_run(input int rdelay, input int fdone_at, input int vmode,
                           input bit seq_data, input int n_accept);
    src_list.delete();
    exp_q.delete();
    for (int i = 0; i < NUM; i++) begin
      if (seq_data) src_list.push_back(DW'(i + 1));
      else          src_list.push_back(DW'($urandom));
    end
    for (int i = 0; i < rdelay; i++) exp_q.push_back('{cmd: CMD_RST, data: '0});
    for (int i = 0; i < n_accept; i++) exp_q.push_back('{cmd: CMD_CENTER_FILL, data: src_list[i]});
    exp_q.push_back('{cmd: CMD_START_SORTING, data: '0});
    rst_delay    = rdelay;
    fill_done_at = fdone_at;
    tree_mute    = 0;
    valid_mode   = vmode;
    src_idx      = 0;
    src_active   = 1;
    busy_cycles  = 0;
    done_seen    = 0;
    ss_cyc       = -1;
    done_cyc     = -1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", 32'(busy), 1);
    check("error_after_start", 32'(error), 0);
  endtask

  // Waits for done and checks the run-level results
  task automatic finish_run(input string tag, input int n_accept);
    for (int k = 0; k < 3000 && !done_seen; k++) @(negedge clk);
    check("run_reaches_done", 32'(done_seen), 1);
    @(negedge clk);
    check("drain_length", 32'(done_cyc - ss_cyc), 32'(STALL + 1));
    check("cycle_count_final", 32'(cycle_count), 32'(busy_cycles));
    check("all_words_seen", 32'(exp_q.size()), 0);
    check("busy_low_after", 32'(busy), 0);
    check("error_low_after", 32'(error), 0);
    src_active = 0;
    $display("run %s: centers=%0d busy_cycles=%0d cycle_count=%0d", tag, n_accept,
             busy_cycles, cycle_count);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cmd"}, 32'(cmd_to_root), 32'(CMD_NOP));
    check({tag, "_data"}, 32'(data_to_root), 0);
    check({tag, "_ready"}, 32'(center_ready), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_error"}, 32'(error), 0);
    check({tag, "_count"}, 32'(cycle_count), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit: simulation still running");
    $fatal(1, "time limit");
  end

  initial begin
    int r;
    int c0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_values("reset");
    $display("reset: outputs checked");

    // Sequential data, valid held high, rst_done after 3 rst cycles
    start_run(3, NUM, 0, 1, NUM);
    finish_run("held_valid", NUM);

    // Valid toggling every other cycle
    start_run(2, NUM, 1, 0, NUM);
    finish_run("toggle_valid", NUM);

    // Tree full after 6 words; the center handshaked in that same cycle is
    // still forwarded, so 7 centers reach the bus and the rest stay unsent.
    start_run(3, 6, 0, 0, 7);
    finish_run("early_full", 7);

    // Random valid pattern and random rst latency
    for (int i = 0; i < 3; i++) begin
      r = int'($urandom_range(1, 5));
      start_run(r, NUM, 2, 0, NUM);
      finish_run("random_valid", NUM);
    end

    // Start while busy is ignored, then reset aborts in DRAIN
    start_run(2, NUM, 0, 0, NUM);
    for (int k = 0; k < 500 && ss_cyc < 0; k++) @(negedge clk);
    check("reached_sort", 32'(ss_cyc >= 0), 1);
    repeat (3) @(posedge clk);
    #1;
    c0 = int'(cycle_count);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_start_count", 32'(cycle_count), 32'(c0 + 1));
    check("busy_start_busy", 32'(busy), 1);
    check("busy_start_cmd", 32'(cmd_to_root), 32'(CMD_NOP));
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_values("mid_reset");
    check("mid_reset_words", 32'(exp_q.size()), 0);
    reset = 1'b0;
    src_active = 0;
    $display("run mid_drain_reset: cycle_count before start=%0d", c0);
    repeat (2) @(posedge clk);
    #1;

    // The next run after an abort re-issues rst and completes
    start_run(3, NUM, 0, 1, NUM);
    finish_run("after_reset", NUM);

`ifdef KD_SEQ_TIMEOUT_EN
    // Tree never answers rst: error after TO cycles, bus back to nop
    exp_q.delete();
    for (int i = 0; i < TO; i++) exp_q.push_back('{cmd: CMD_RST, data: '0});
    tree_mute   = 1;
    busy_cycles = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 200 && !error; k++) @(negedge clk);
    check("timeout_error", 32'(error), 1);
    check("timeout_busy", 32'(busy), 0);
    check("timeout_count", 32'(cycle_count), 32'(TO));
    check("timeout_rst_words", 32'(exp_q.size()), 0);
    repeat (5) @(negedge clk);
    check("timeout_frozen", 32'(cycle_count), 32'(TO));
    check("timeout_sticky", 32'(error), 1);
    $display("run timeout: cycle_count=%0d error=%0b", cycle_count, error);
    start_run(3, NUM, 0, 0, NUM);
    finish_run("restart_after_error", NUM);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/kd_tree_sequencer.md
# kd_tree_sequencer

Synthesizable sequencer that drives the root node of the kd-tree over its command/data port. It replaces hand-written bench sequencing with parametrised hardware: tree reset, streaming NUM_CENTERS centers, launching the sort, and a post-sort drain window. It sits between the center source (host or center memory) and the root `node`. It reports busy/done/error plus a run-length cycle count.

## Interface
Parameters:
- DATA_W, 24, width of one center/pixel word (RGB 8:8:8)
- CMD_W, 5, width of the node command bus
- NUM_CENTERS, 10, number of centers streamed per run (1..1023)
- STALL_CYCLES, 10, nop cycles driven after start_sorting before done
- TIMEOUT, 1024, watchdog limit in cycles per wait state (only with KD_SEQ_TIMEOUT_EN)
- CNT_W, 27, width of cycle_count (covers 10^8 cycles)

Ports:
- clk  in  1  clock; one clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle run request; honoured only in IDLE or ERROR
- center_valid  in  1  center_data holds a valid center
- center_data  in  DATA_W  center word
- center_ready  out  1  sequencer accepts center_data this cycle
- cmd_to_root  out  CMD_W  registered command to root command_from_top
- data_to_root  out  DATA_W  registered data to root data_from_top
- cmd_from_root  in  CMD_W  root command_to_top
- busy  out  1  high from accepted start until DONE/ERROR
- done  out  1  one-cycle pulse at run completion
- error  out  1  sticky watchdog flag, cleared by start or reset
- cycle_count  out  CNT_W  cycles since accepted start, saturating, frozen at done/error

## Operation
- States: IDLE, TREE_RST, FILL, FILL_WAIT, SORT, DRAIN, DONE, ERROR.
- IDLE: drive nop, data 0. On start, clear fill_cnt, cycle_count, and error, then go to TREE_RST.
- TREE_RST: drive rst every cycle. When cmd_from_root==rst_done, go to FILL.
- FILL:
  - center_ready = (state==FILL) && fill_cnt<NUM_CENTERS. This is combinational from state and counter only, never from center_valid.
  - On valid&&ready: register cmd center_fill with data center_data and increment fill_cnt.
  - Without a handshake: drive nop, data held.
  - When fill_cnt reaches NUM_CENTERS, go to FILL_WAIT.
- FILL_WAIT: drive nop. When cmd_from_root==center_fill_done, go to SORT.
- Early center_fill_done during FILL (tree full before NUM_CENTERS): stop accepting, then go to SORT. Unsent centers stay with the source.
- SORT: drive start_sorting with data 0 for exactly one cycle, load the drain counter with STALL_CYCLES, and go to DRAIN.
- DRAIN: drive nop and decrement. At 0, go to DONE.
- DONE: done=1 for one cycle, busy=0, then return to IDLE.
- ERROR: drive nop, error=1, busy=0. Hold until start (restarts at TREE_RST) or reset.
- start is ignored while busy.
- cycle_count increments every cycle while busy and saturates at all-ones.

## Timing
- Reset values: cmd_to_root=nop (0x00), data_to_root=0, center_ready=0, busy=0, done=0, error=0, cycle_count=0, state IDLE.
- A reset asserted mid-run aborts on the next edge and gives reset values. The tree is not notified; the next run re-issues rst.
- start sampled at edge N: busy and cmd_to_root=rst are visible after edge N.
- Center handshake at edge N: center_fill plus data appear on the bus after edge N, so the root sees them in cycle N+1. There is one bus word per accepted center, with no bubbles when valid is held high.
- rst_done or center_fill_done seen at edge N: the state changes at N. The next command is visible after edge N+1 at the earliest.
- The first start_sorting is always preceded by at least one nop (FILL_WAIT).
- Total DRAIN length is STALL_CYCLES+1 nop cycles including the load cycle; done is asserted on the following cycle.

## Configuration
- KD_SEQ_TIMEOUT_EN defined: a watchdog counts cycles in TREE_RST, FILL_WAIT, and FILL with no handshake. The count clears on each state entry and on each handshake.
  - Reaching TIMEOUT → ERROR, with error=1 and cycle_count frozen.
- Undefined: no watchdog logic, waits are unbounded, error tied 0, and the ERROR state is unreachable.

## Structure
- Shared package kd_tree_pkg holds:
  - command encodings: nop 0x00, center_fill 0x01, center_fill_done 0x05, start_sorting 0x09, ready_to_sort 0x0a, dne 0x10, rst_done 0x1e, rst 0x1f
  - the sequencer state enum
  - CMD_W
- The `node` and bench use the same package.
- One sub-module: kd_seq_watchdog (clear, enable, TIMEOUT parameter, expired output). It is instantiated only under KD_SEQ_TIMEOUT_EN.

## Test plan
- Reset then start, with a model tree returning rst_done 3 cycles later: rst is on the bus for 3 cycles, and center_ready rises on the cycle after rst_done.
- NUM_CENTERS=10, valid held high, data 0x000001..0x00000A: bus shows center_fill with 0x000001..0x00000A on 10 consecutive cycles, then nop, and center_ready=0.
- Valid toggling every other cycle: center_fill only in handshake cycles, nop between, and no data lost or duplicated.
- center_fill_done returned after 6 centers: no further center_ready, one start_sorting, 11 nop cycles, a done pulse, and busy falls.
- KD_SEQ_TIMEOUT_EN, TIMEOUT=16, tree never sends rst_done: error=1 after 16 cycles in TREE_RST and the bus stays nop. A new start clears error and re-issues rst.
- Reset asserted in DRAIN and start pulsed while busy: reset forces all reset values next cycle, and a start while busy has no effect on state or cycle_count.
